// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter
//   Shares one AHB master command port among NREQ pixel-engine requesters. Round-robin
//   grant, one transaction in flight. The winner's command is captured at grant and held
//   on the master port for the whole BUSY state. Read data or error is routed back to the
//   winner in a single RESP cycle.
//
// Ports
//   clk, n_rst                          clock (rising edge), async active-low reset
//   req_valid/write/pixnum/wdata/sel    packed per-requester command fields
//   gnt                                 one-hot pulse, request accepted and captured
//   rsp_valid, rsp_rdata, rsp_err       one-hot completion pulse, read data, error flag
//   hang                                watchdog flag, cleared at next completion
//   m_mode/m_pixnum/m_wdata/m_sel/m_size  command to the AHB master
//   m_feedback, m_rdata, m_error        completion signals from the AHB master
module ahb_master_arbiter #(
    parameter int unsigned NREQ        = 3,
    parameter logic [1:0]  XFER_SIZE   = 2'b10,
    parameter int unsigned WDOG_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*20-1:0]   req_pixnum,
    input  logic [NREQ*32-1:0]   req_wdata,
    input  logic [NREQ-1:0]      req_sel,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 hang,
    output logic [1:0]           m_mode,
    output logic [19:0]          m_pixnum,
    output logic [31:0]          m_wdata,
    output logic                 m_sel,
    output logic [1:0]           m_size,
    input  logic                 m_feedback,
    input  logic [31:0]          m_rdata,
    input  logic                 m_error
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StArb, StBusy, StResp} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   winner_q, winner_d;
    logic            write_q, write_d;
    logic [19:0]     pixnum_q, pixnum_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            sel_q, sel_d;
    logic            err_q, err_d;
    logic [15:0]     wdog_q, wdog_d;
    logic            hang_q, hang_d;

    logic            found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;

    // Round-robin search: first valid requester scanning ptr, ptr+1, ... modulo NREQ.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = PW'((int'(ptr_q) + i) % NREQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        write_d  = write_q;
        pixnum_d = pixnum_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        err_d    = err_q;
        wdog_d   = wdog_q;
        hang_d   = hang_q;

        gnt       = '0;
        rsp_valid = '0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        m_mode    = 2'b00;
        m_pixnum  = '0;
        m_wdata   = '0;
        m_sel     = 1'b0;

        unique case (state_q)
            StArb: begin
                if (found) begin
                    gnt[win_idx] = 1'b1;
                    winner_d     = win_idx;
                    write_d      = req_write[win_idx];
                    pixnum_d     = req_pixnum[20*win_idx +: 20];
                    wdata_d      = req_wdata[32*win_idx +: 32];
                    sel_d        = req_sel[win_idx];
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                m_mode   = write_q ? 2'b10 : 2'b01;
                m_pixnum = pixnum_q;
                m_wdata  = wdata_q;
                m_sel    = sel_q;
                if (wdog_q != 16'hFFFF) begin
                    wdog_d = wdog_q + 16'd1;
                end
                // Flag only; the transaction keeps waiting for the master.
                if (wdog_d >= 16'(WDOG_CYCLES)) begin
                    hang_d = 1'b1;
                end
                // Error takes priority when both arrive in the same cycle.
                if (m_error) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (m_feedback) begin
                    err_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StResp: begin
                rsp_valid[winner_q] = 1'b1;
                rsp_err             = err_q;
                // Master presents read data the cycle after m_feedback.
                rsp_rdata = (!write_q && !err_q) ? m_rdata : 32'd0;
                ptr_d     = (int'(winner_q) == NREQ - 1) ? '0 : winner_q + PW'(1);
                wdog_d    = '0;
                hang_d    = 1'b0;
                state_d   = StArb;
            end
            default: begin
                state_d = StArb;
            end
        endcase
    end

    assign hang   = hang_q;
    assign m_size = XFER_SIZE;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= StArb;
            ptr_q    <= '0;
            winner_q <= '0;
            write_q  <= 1'b0;
            pixnum_q <= '0;
            wdata_q  <= '0;
            sel_q    <= 1'b0;
            err_q    <= 1'b0;
            wdog_q   <= '0;
            hang_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            write_q  <= write_d;
            pixnum_q <= pixnum_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
            hang_q   <= hang_d;
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter (NREQ=3, WDOG_CYCLES=255).
module tb_ahb_master_arbiter;

    localparam int unsigned NREQ = 3;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_write = '0;
    logic [NREQ*20-1:0] req_pixnum = '0;
    logic [NREQ*32-1:0] req_wdata = '0;
    logic [NREQ-1:0]   req_sel = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              hang;
    logic [1:0]        m_mode;
    logic [19:0]       m_pixnum;
    logic [31:0]       m_wdata;
    logic              m_sel;
    logic [1:0]        m_size;
    logic              m_feedback = 1'b0;
    logic [31:0]       m_rdata = '0;
    logic              m_error = 1'b0;

    int checks = 0;
    int errors = 0;

    ahb_master_arbiter #(
        .NREQ       (NREQ),
        .XFER_SIZE  (2'b10),
        .WDOG_CYCLES(255)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_pixnum(req_pixnum),
        .req_wdata (req_wdata),
        .req_sel   (req_sel),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .hang      (hang),
        .m_mode    (m_mode),
        .m_pixnum  (m_pixnum),
        .m_wdata   (m_wdata),
        .m_sel     (m_sel),
        .m_size    (m_size),
        .m_feedback(m_feedback),
        .m_rdata   (m_rdata),
        .m_error   (m_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow a further #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in BUSY cycle 1; completion is signalled in BUSY cycle n, returns in RESP
    // with the master's read data presented.
    task automatic serve(input int n, input bit err, input logic [31:0] rd);
        for (int c = 1; c < n; c++) tick();
        m_feedback = 1'b1;
        m_error    = err;
        tick();
        m_feedback = 1'b0;
        m_error    = 1'b0;
        m_rdata    = rd;
        #1;
    endtask

    initial begin
        // Reset values
        #12;
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_rsp", 32'(rsp_valid), 32'd0);
        check_eq("rst_mode", 32'(m_mode), 32'd0);
        check_eq("rst_hang", 32'(hang), 32'd0);
        check_eq("rst_size", 32'(m_size), 32'd2);
        n_rst = 1'b1;

        // Single read on req0, zero-wait slave: gnt t0, BUSY t1..t3, rsp t4
        tick();
        req_valid = 3'b001;
        req_write = 3'b000;
        req_pixnum[0 +: 20] = 20'h00010;
        #1;
        check_eq("rd_gnt", 32'(gnt), 32'b001);
        check_eq("rd_mode_t0", 32'(m_mode), 32'd0);
        tick();
        req_valid = '0;
        req_pixnum = '0;
        #1;
        check_eq("rd_mode_t1", 32'(m_mode), 32'b01);
        check_eq("rd_pix_t1", 32'(m_pixnum), 32'h10);
        check_eq("rd_gnt_t1", 32'(gnt), 32'd0);
        tick();
        #1;
        check_eq("rd_mode_t2", 32'(m_mode), 32'b01);
        tick();
        m_feedback = 1'b1;
        #1;
        check_eq("rd_mode_t3", 32'(m_mode), 32'b01);
        check_eq("rd_norsp_t3", 32'(rsp_valid), 32'd0);
        tick();
        m_feedback = 1'b0;
        m_rdata = 32'hDEADBEEF;
        #1;
        check_eq("rd_rsp_t4", 32'(rsp_valid), 32'b001);
        check_eq("rd_data", rsp_rdata, 32'hDEADBEEF);
        check_eq("rd_err", 32'(rsp_err), 32'd0);
        check_eq("rd_mode_t4", 32'(m_mode), 32'd0);
        tick();
        m_rdata = '0;
        #1;
        check_eq("rd_rsp_t5", 32'(rsp_valid), 32'd0);

        // Write on req1 (ptr is now 1); requester scrambles fields after gnt
        req_valid = 3'b010;
        req_write = 3'b010;
        req_pixnum[20 +: 20] = 20'h00ABC;
        req_wdata[32 +: 32] = 32'h12345678;
        req_sel = 3'b010;
        #1;
        check_eq("wr_gnt", 32'(gnt), 32'b010);
        tick();
        req_valid = '0;
        req_write = '0;
        req_pixnum = '1;
        req_wdata = '1;
        req_sel = '0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) m_feedback = 1'b1;
            #1;
            check_eq("wr_mode", 32'(m_mode), 32'b10);
            check_eq("wr_wdata", m_wdata, 32'h12345678);
            check_eq("wr_sel", 32'(m_sel), 32'd1);
            check_eq("wr_pix", 32'(m_pixnum), 32'h00ABC);
            tick();
        end
        m_feedback = 1'b0;
        m_rdata = 32'hFFFFFFFF;
        #1;
        check_eq("wr_rsp", 32'(rsp_valid), 32'b010);
        check_eq("wr_rdata", rsp_rdata, 32'd0);
        tick();
        m_rdata = '0;
        req_pixnum = '0;
        req_wdata = '0;

        // Read on req2 ends with error (feedback in same cycle); rdata must be zeroed
        req_valid = 3'b100;
        #1;
        check_eq("er_gnt", 32'(gnt), 32'b100);
        tick();
        req_valid = '0;
        serve(2, 1'b1, 32'hCAFEF00D);
        check_eq("er_rsp", 32'(rsp_valid), 32'b100);
        check_eq("er_err", 32'(rsp_err), 32'd1);
        check_eq("er_rdata", rsp_rdata, 32'd0);
        tick();
        m_rdata = '0;

        // Next request after the error is served normally; feedback in ARB ignored
        m_feedback = 1'b1;
        #1;
        check_eq("ign_fb", 32'(rsp_valid), 32'd0);
        m_feedback = 1'b0;
        req_valid = 3'b001;
        #1;
        check_eq("nx_gnt", 32'(gnt), 32'b001);
        tick();
        req_valid = '0;
        serve(3, 1'b0, 32'h0000A5A5);
        check_eq("nx_rsp", 32'(rsp_valid), 32'b001);
        check_eq("nx_err", 32'(rsp_err), 32'd0);
        check_eq("nx_rdata", rsp_rdata, 32'h0000A5A5);
        tick();
        m_rdata = '0;

        // Watchdog: req1 read stalls 300 BUSY cycles
        req_valid = 3'b010;
        #1;
        check_eq("wd_gnt", 32'(gnt), 32'b010);
        tick();
        req_valid = '0;
        for (int c = 1; c < 255; c++) tick();
        #1;
        check_eq("wd_hang_254", 32'(hang), 32'd0);
        tick();
        #1;
        check_eq("wd_hang_255", 32'(hang), 32'd1);
        check_eq("wd_mode", 32'(m_mode), 32'b01);
        serve(45, 1'b0, 32'h11112222);
        check_eq("wd_rsp", 32'(rsp_valid), 32'b010);
        check_eq("wd_hang_rsp", 32'(hang), 32'd1);
        check_eq("wd_rdata", rsp_rdata, 32'h11112222);
        tick();
        m_rdata = '0;
        #1;
        check_eq("wd_hang_clr", 32'(hang), 32'd0);

        // Reset mid-BUSY on req2 (ptr is 2)
        req_valid = 3'b100;
        #1;
        check_eq("rb_gnt", 32'(gnt), 32'b100);
        tick();
        req_valid = '0;
        #1;
        check_eq("rb_mode_pre", 32'(m_mode), 32'b01);
        n_rst = 1'b0;
        #1;
        check_eq("rb_mode", 32'(m_mode), 32'd0);
        check_eq("rb_gnt0", 32'(gnt), 32'd0);
        check_eq("rb_rsp0", 32'(rsp_valid), 32'd0);
        tick();
        tick();
        n_rst = 1'b1;

        // All three requesting continuously: order 0,1,2,0,1,2 from the reset pointer
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            logic [2:0] exp_oh;
            exp_oh = 3'b001 << (k % 3);
            #1;
            check_eq("rr_gnt", 32'(gnt), 32'(exp_oh));
            tick();
            #1;
            check_eq("rr_busy_nogr", 32'(gnt), 32'd0);
            serve(3, 1'b0, 32'(k + 100));
            check_eq("rr_rsp", 32'(rsp_valid), 32'(exp_oh));
            check_eq("rr_rsp_nogr", 32'(gnt), 32'd0);
            check_eq("rr_rdata", rsp_rdata, 32'(k + 100));
            tick();
            m_rdata = '0;
        end
        req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
